// File: rtl/time_counter.sv
// Real-time clock counter: BCD seconds/minutes/hours with a RUN / SET_HR / SET_MIN
// front panel driven by two level buttons. FMT24 picks a 24-hour or 12-hour (with pm) display.
module time_counter #(
    parameter bit FMT24 = 1'b1
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       tick,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [3:0] sec_u,
    output logic [3:0] sec_t,
    output logic [3:0] min_u,
    output logic [3:0] min_t,
    output logic [3:0] hr_u,
    output logic [3:0] hr_t,
    output logic       pm,
    output logic [1:0] mode,
    output logic       day_pulse
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    localparam logic [3:0] HR_T_RST = FMT24 ? 4'd0 : 4'd1;
    localparam logic [3:0] HR_U_RST = FMT24 ? 4'd0 : 4'd2;

    state_t     state_reg, state_next;
    logic       mode_q_reg, inc_q_reg;
    logic       mode_edge, inc_edge;

    logic [3:0] sec_u_reg, sec_t_reg, min_u_reg, min_t_reg, hr_u_reg, hr_t_reg;
    logic [3:0] sec_u_next, sec_t_next, min_u_next, min_t_next, hr_u_next, hr_t_next;
    logic       pm_reg, pm_next;
    logic       day_pulse_reg, day_pulse_next;

    logic [3:0] sec_u_inc, sec_t_inc, min_u_inc, min_t_inc, hr_u_inc, hr_t_inc;
    logic       sec_wrap, min_wrap, pm_inc, day_inc;

    assign mode_edge = mode_btn & ~mode_q_reg;
    assign inc_edge  = inc_btn & ~inc_q_reg;

    // State register
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (mode_edge) state_next = SET_HR;
            SET_HR:  if (mode_edge) state_next = SET_MIN;
            SET_MIN: if (mode_edge) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Output logic
    always_comb begin
        mode = state_reg;
    end

    // Sixty-count BCD incrementers for seconds and minutes
    always_comb begin
        sec_wrap  = (sec_t_reg == 4'd5) && (sec_u_reg == 4'd9);
        sec_u_inc = (sec_u_reg == 4'd9) ? 4'd0 : sec_u_reg + 4'd1;
        sec_t_inc = (sec_u_reg != 4'd9) ? sec_t_reg : (sec_t_reg == 4'd5) ? 4'd0 : sec_t_reg + 4'd1;
        min_wrap  = (min_t_reg == 4'd5) && (min_u_reg == 4'd9);
        min_u_inc = (min_u_reg == 4'd9) ? 4'd0 : min_u_reg + 4'd1;
        min_t_inc = (min_u_reg != 4'd9) ? min_t_reg : (min_t_reg == 4'd5) ? 4'd0 : min_t_reg + 4'd1;
    end

    // Hour incrementer; day_inc marks the midnight rollover (23->00, or 11pm->12am)
    always_comb begin
        hr_t_inc = hr_t_reg;
        hr_u_inc = hr_u_reg + 4'd1;
        pm_inc   = pm_reg;
        day_inc  = 1'b0;
        if (FMT24) begin
            if (hr_t_reg == 4'd2 && hr_u_reg == 4'd3) begin
                hr_t_inc = 4'd0;
                hr_u_inc = 4'd0;
                day_inc  = 1'b1;
            end else if (hr_u_reg == 4'd9) begin
                hr_t_inc = hr_t_reg + 4'd1;
                hr_u_inc = 4'd0;
            end
        end else begin
            if (hr_t_reg == 4'd1 && hr_u_reg == 4'd2) begin
                hr_t_inc = 4'd0;
                hr_u_inc = 4'd1;
            end else if (hr_t_reg == 4'd1 && hr_u_reg == 4'd1) begin
                hr_u_inc = 4'd2;
                pm_inc   = ~pm_reg;
                day_inc  = pm_reg;
            end else if (hr_u_reg == 4'd9) begin
                hr_t_inc = 4'd1;
                hr_u_inc = 4'd0;
            end
        end
    end

    // Time datapath; a mode press in a SET state wins over a simultaneous increment
    always_comb begin
        sec_u_next     = sec_u_reg;
        sec_t_next     = sec_t_reg;
        min_u_next     = min_u_reg;
        min_t_next     = min_t_reg;
        hr_u_next      = hr_u_reg;
        hr_t_next      = hr_t_reg;
        pm_next        = pm_reg;
        day_pulse_next = 1'b0;
        case (state_reg)
            RUN: begin
                if (tick) begin
                    sec_u_next = sec_u_inc;
                    sec_t_next = sec_t_inc;
                    if (sec_wrap) begin
                        min_u_next = min_u_inc;
                        min_t_next = min_t_inc;
                        if (min_wrap) begin
                            hr_u_next      = hr_u_inc;
                            hr_t_next      = hr_t_inc;
                            pm_next        = pm_inc;
                            day_pulse_next = day_inc;
                        end
                    end
                end
            end
            SET_HR: begin
                if (inc_edge && !mode_edge) begin
                    hr_u_next = hr_u_inc;
                    hr_t_next = hr_t_inc;
                    pm_next   = pm_inc;
                end
            end
            SET_MIN: begin
                if (mode_edge) begin
                    sec_u_next = 4'd0;
                    sec_t_next = 4'd0;
                end else if (inc_edge) begin
                    min_u_next = min_u_inc;
                    min_t_next = min_t_inc;
                end
            end
            default: ;
        endcase
    end

    // Button history resets high so a button held through reset is not seen as a press
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            mode_q_reg    <= 1'b1;
            inc_q_reg     <= 1'b1;
            sec_u_reg     <= 4'd0;
            sec_t_reg     <= 4'd0;
            min_u_reg     <= 4'd0;
            min_t_reg     <= 4'd0;
            hr_u_reg      <= HR_U_RST;
            hr_t_reg      <= HR_T_RST;
            pm_reg        <= 1'b0;
            day_pulse_reg <= 1'b0;
        end else begin
            mode_q_reg    <= mode_btn;
            inc_q_reg     <= inc_btn;
            sec_u_reg     <= sec_u_next;
            sec_t_reg     <= sec_t_next;
            min_u_reg     <= min_u_next;
            min_t_reg     <= min_t_next;
            hr_u_reg      <= hr_u_next;
            hr_t_reg      <= hr_t_next;
            pm_reg        <= pm_next;
            day_pulse_reg <= day_pulse_next;
        end
    end

    assign sec_u     = sec_u_reg;
    assign sec_t     = sec_t_reg;
    assign min_u     = min_u_reg;
    assign min_t     = min_t_reg;
    assign hr_u      = hr_u_reg;
    assign hr_t      = hr_t_reg;
    assign pm        = pm_reg;
    assign day_pulse = day_pulse_reg;

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter: a 24-hour instance driven from a vector table plus
// hand sequences, and a 12-hour instance on the same stimulus for the pm/day corners.
module tb_time_counter;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       tick;
    logic       mode_btn;
    logic       inc_btn;

    logic [3:0] a_sec_u, a_sec_t, a_min_u, a_min_t, a_hr_u, a_hr_t;
    logic       a_pm, a_day;
    logic [1:0] a_mode;
    logic [3:0] b_sec_u, b_sec_t, b_min_u, b_min_t, b_hr_u, b_hr_t;
    logic       b_pm, b_day;
    logic [1:0] b_mode;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    time_counter #(.FMT24(1'b1)) u_dut24 (
        .clk_in(clk_in), .rst(rst), .tick(tick), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .sec_u(a_sec_u), .sec_t(a_sec_t), .min_u(a_min_u), .min_t(a_min_t),
        .hr_u(a_hr_u), .hr_t(a_hr_t), .pm(a_pm), .mode(a_mode), .day_pulse(a_day)
    );

    time_counter #(.FMT24(1'b0)) u_dut12 (
        .clk_in(clk_in), .rst(rst), .tick(tick), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .sec_u(b_sec_u), .sec_t(b_sec_t), .min_u(b_min_u), .min_t(b_min_t),
        .hr_u(b_hr_u), .hr_t(b_hr_t), .pm(b_pm), .mode(b_mode), .day_pulse(b_day)
    );

    localparam int OP_TICK = 0;
    localparam int OP_MODE = 1;
    localparam int OP_INC  = 2;

    typedef struct {
        int          op;
        int          n;
        logic [23:0] t;
        logic [1:0]  mode;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [31:0] pack(logic [23:0] t, logic p, logic d, logic [1:0] m);
        return {t, 3'b000, p, 1'b0, d, m};
    endfunction

    function automatic logic [31:0] snap24();
        return pack({a_hr_t, a_hr_u, a_min_t, a_min_u, a_sec_t, a_sec_u}, a_pm, a_day, a_mode);
    endfunction

    function automatic logic [31:0] snap12();
        return pack({b_hr_t, b_hr_u, b_min_t, b_min_u, b_sec_t, b_sec_u}, b_pm, b_day, b_mode);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (hhmmss_pm_day_mode)", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_ticks(int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    task automatic press_mode();
        mode_btn = 1'b1;
        step();
        mode_btn = 1'b0;
        step();
    endtask

    task automatic press_inc(int n);
        repeat (n) begin
            inc_btn = 1'b1;
            step();
            inc_btn = 1'b0;
            step();
        end
    endtask

    initial begin
        vecs[0]  = '{OP_TICK,   60, 24'h000100, 2'd0};
        vecs[1]  = '{OP_TICK, 3540, 24'h010000, 2'd0};
        vecs[2]  = '{OP_TICK,   37, 24'h010037, 2'd0};
        vecs[3]  = '{OP_MODE,    1, 24'h010037, 2'd1};
        vecs[4]  = '{OP_MODE,    1, 24'h010037, 2'd2};
        vecs[5]  = '{OP_MODE,    1, 24'h010000, 2'd0};
        vecs[6]  = '{OP_INC,     3, 24'h010000, 2'd0};
        vecs[7]  = '{OP_MODE,    1, 24'h010000, 2'd1};
        vecs[8]  = '{OP_INC,    22, 24'h230000, 2'd1};
        vecs[9]  = '{OP_TICK,    5, 24'h230000, 2'd1};
        vecs[10] = '{OP_MODE,    1, 24'h230000, 2'd2};
        vecs[11] = '{OP_INC,    59, 24'h235900, 2'd2};
        vecs[12] = '{OP_MODE,    1, 24'h235900, 2'd0};
        vecs[13] = '{OP_TICK,   59, 24'h235959, 2'd0};

        rst = 1'b0; tick = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
        #12;
        check("reset24", snap24(), pack(24'h000000, 1'b0, 1'b0, 2'd0));
        check("reset12", snap12(), pack(24'h120000, 1'b0, 1'b0, 2'd0));
        rst = 1'b1;
        step();

        for (int i = 0; i < 14; i++) begin
            case (vecs[i].op)
                OP_TICK: do_ticks(vecs[i].n);
                OP_MODE: press_mode();
                default: press_inc(vecs[i].n);
            endcase
            check($sformatf("vec%0d", i), snap24(), pack(vecs[i].t, 1'b0, 1'b0, vecs[i].mode));
        end

        // Midnight rollover
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("day_wrap", snap24(), pack(24'h000000, 1'b0, 1'b1, 2'd0));
        step();
        check("day_end", snap24(), pack(24'h000000, 1'b0, 1'b0, 2'd0));

        do_ticks(7);
        check("run7", snap24(), pack(24'h000007, 1'b0, 1'b0, 2'd0));
        press_mode();
        press_inc(23);
        check("sethr23", snap24(), pack(24'h230007, 1'b0, 1'b0, 2'd1));
        inc_btn = 1'b1;
        step();
        check("sethr_wrap", snap24(), pack(24'h000007, 1'b0, 1'b0, 2'd1));
        inc_btn = 1'b0;
        step();
        press_mode();
        press_inc(59);
        check("setmin59", snap24(), pack(24'h005907, 1'b0, 1'b0, 2'd2));
        inc_btn = 1'b1;
        repeat (10) step();
        inc_btn = 1'b0;
        step();
        check("held_inc", snap24(), pack(24'h000007, 1'b0, 1'b0, 2'd2));
        do_ticks(5);
        check("frozen", snap24(), pack(24'h000007, 1'b0, 1'b0, 2'd2));

        mode_btn = 1'b1; inc_btn = 1'b1;
        step();
        mode_btn = 1'b0; inc_btn = 1'b0;
        step();
        check("mode_inc_same", snap24(), pack(24'h000000, 1'b0, 1'b0, 2'd0));

        tick = 1'b1; mode_btn = 1'b1;
        step();
        tick = 1'b0; mode_btn = 1'b0;
        check("tick_mode_same", snap24(), pack(24'h000001, 1'b0, 1'b0, 2'd1));
        step();
        press_inc(5);
        check("sethr5", snap24(), pack(24'h050001, 1'b0, 1'b0, 2'd1));

        // Asynchronous reset mid-cycle while editing, buttons held through release
        #3;
        rst = 1'b0; mode_btn = 1'b1; inc_btn = 1'b1;
        #1;
        check("async_rst", snap24(), pack(24'h000000, 1'b0, 1'b0, 2'd0));
        #2;
        rst = 1'b1;
        repeat (3) step();
        check("held_thru_rst", snap24(), pack(24'h000000, 1'b0, 1'b0, 2'd0));
        mode_btn = 1'b0; inc_btn = 1'b0;
        do_ticks(1);
        check("resume", snap24(), pack(24'h000001, 1'b0, 1'b0, 2'd0));

        // 12-hour instance
        #3;
        rst = 1'b0;
        #1;
        check("reset12_b", snap12(), pack(24'h120000, 1'b0, 1'b0, 2'd0));
        #2;
        rst = 1'b1;
        step();
        press_mode();
        press_inc(11);
        check("h12_set11", snap12(), pack(24'h110000, 1'b0, 1'b0, 2'd1));
        press_mode();
        press_inc(59);
        press_mode();
        do_ticks(59);
        check("h12_115959", snap12(), pack(24'h115959, 1'b0, 1'b0, 2'd0));
        do_ticks(1);
        check("h12_noon", snap12(), pack(24'h120000, 1'b1, 1'b0, 2'd0));
        do_ticks(3599);
        check("h12_125959", snap12(), pack(24'h125959, 1'b1, 1'b0, 2'd0));
        do_ticks(1);
        check("h12_one", snap12(), pack(24'h010000, 1'b1, 1'b0, 2'd0));
        press_mode();
        press_inc(10);
        check("h12_set11pm", snap12(), pack(24'h110000, 1'b1, 1'b0, 2'd1));
        press_mode();
        press_inc(59);
        press_mode();
        do_ticks(59);
        check("h12_pm115959", snap12(), pack(24'h115959, 1'b1, 1'b0, 2'd0));
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("h12_midnight", snap12(), pack(24'h120000, 1'b0, 1'b1, 2'd0));
        step();
        check("h12_day_end", snap12(), pack(24'h120000, 1'b0, 1'b0, 2'd0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
